// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared definitions for the cpu_mem_arbiter slice.
//   arb_state_e : arbiter FSM states (idle, issuing to memory, waiting for response)
//   arb_src_e   : requester codes (instruction fetch / load-store)
//   Default*    : default address/data widths and timeout used by the arbiter modules
package cpu_mem_arbiter_pkg;

  localparam int unsigned DefaultAw      = 32;
  localparam int unsigned DefaultDw      = 32;
  localparam int unsigned DefaultTimeout = 255;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } arb_state_e;

  typedef enum logic {
    SrcI = 1'b0,
    SrcD = 1'b1
  } arb_src_e;

endpackage

// File: rtl/cpu_mem_arbiter_timeout_cnt.sv
// Per-transaction watchdog counter for cpu_mem_arbiter.
//   clk     : clock
//   rst_n   : asynchronous reset, active-high
//   clear   : restart the count (transaction start); takes priority over enable
//   enable  : count this cycle (transaction in flight)
//   expired : this is the TIMEOUT-th counted cycle; the arbiter must give up at this edge
module cpu_mem_arbiter_timeout_cnt
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // The arbiter leaves ISSUE/WAIT on the edge where the count reaches TIMEOUT,
  // so the saturation guard never actually engages; it only prevents a wrap.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != CW'(TIMEOUT))) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Flag the cycle whose increment would reach TIMEOUT: after exactly TIMEOUT
  // cycles in ISSUE+WAIT the error response is registered.
  assign expired = enable & (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the cpu_v4
// instruction-fetch port (i_*) and its load/store port (d_*), one outstanding
// transaction, with a per-transaction timeout that returns an error response.
//   clk, rst_n                     : clock, asynchronous active-high reset
//   i_req/i_addr -> i_gnt          : fetch request, accepted when i_gnt (combinational)
//   i_rvalid/i_rdata/i_err         : fetch response pulse, data, timeout flag
//   d_req/d_we/d_addr/d_wdata/d_be : load/store request, accepted when d_gnt
//   d_rvalid/d_rdata/d_err         : load/store response pulse, data, timeout flag
//   mem_req/mem_we/mem_addr/...    : latched memory request, held until mem_ack
//   mem_ack, mem_rvalid, mem_rdata : memory handshake and response
//   busy                           : a transaction is in flight
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int unsigned AW      = DefaultAw,
  parameter int unsigned DW      = DefaultDw,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic            clk,
  input  logic            rst_n,
  // instruction fetch port
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  output logic            i_err,
  // load/store port
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            d_err,
  // memory port
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ack,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  arb_state_e state_q;
  arb_src_e   src_q;
  arb_src_e   last_src_q;
  arb_src_e   pick_src;

  logic            mem_req_q;
  logic            mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic [DW/8-1:0] mem_be_q;
  logic            i_rvalid_q, d_rvalid_q;
  logic            i_err_q, d_err_q;
  logic [DW-1:0]   i_rdata_q, d_rdata_q;

  logic pick_valid;
  logic start;
  logic cnt_en;
  logic expired;
  logic fin_ok;
  logic fin_err;

  // Round-robin picker: on a tie the source that was not served last wins.
  always_comb begin
    pick_src = SrcD;
    if (i_req && d_req) begin
      if (last_src_q == SrcD) begin
        pick_src = SrcI;
      end else begin
        pick_src = SrcD;
      end
    end else if (i_req) begin
      pick_src = SrcI;
    end
  end

  assign pick_valid = i_req | d_req;
  assign start      = (state_q == StIdle) & pick_valid;

  // Grants are combinational; masked while reset is held so all outputs read 0.
  assign i_gnt = start & (pick_src == SrcI) & ~rst_n;
  assign d_gnt = start & (pick_src == SrcD) & ~rst_n;

  assign cnt_en = (state_q == StIssue) | (state_q == StWait);

  cpu_mem_arbiter_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start),
    .enable  (cnt_en),
    .expired (expired)
  );

  // A real response in WAIT beats a simultaneous expiry; responses outside WAIT are stray.
  assign fin_ok  = (state_q == StWait) & mem_rvalid;
  assign fin_err = expired & ~fin_ok;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= StIdle;
      src_q       <= SrcI;
      last_src_q  <= SrcD;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      i_rvalid_q  <= 1'b0;
      i_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      i_rvalid_q <= 1'b0;
      i_err_q    <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;

      if (fin_ok || fin_err) begin
        state_q   <= StIdle;
        mem_req_q <= 1'b0;
        if (src_q == SrcI) begin
          i_rvalid_q <= 1'b1;
          i_err_q    <= fin_err;
          i_rdata_q  <= fin_ok ? mem_rdata : '0;
        end else begin
          d_rvalid_q <= 1'b1;
          d_err_q    <= fin_err;
          d_rdata_q  <= fin_ok ? mem_rdata : '0;
        end
      end else begin
        case (state_q)
          StIdle: begin
            if (start) begin
              state_q    <= StIssue;
              src_q      <= pick_src;
              last_src_q <= pick_src;
              mem_req_q  <= 1'b1;
              if (pick_src == SrcI) begin
                mem_we_q    <= 1'b0;
                mem_addr_q  <= i_addr;
                mem_wdata_q <= '0;
                mem_be_q    <= '1;
              end else begin
                mem_we_q    <= d_we;
                mem_addr_q  <= d_addr;
                mem_wdata_q <= d_wdata;
                mem_be_q    <= d_be;
              end
            end
          end
          StIssue: begin
            if (mem_ack) begin
              state_q   <= StWait;
              mem_req_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign i_rvalid  = i_rvalid_q;
  assign i_err     = i_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter: directed scenarios followed by
// randomized transactions, checked against a transaction-level timing model.
module tb_cpu_mem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_req, mem_we, mem_ack, mem_rvalid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  cpu_mem_arbiter #(
    .AW      (32),
    .DW      (32),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_gnt      (i_gnt),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .i_err      (i_err),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_be       (d_be),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .d_err      (d_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  typedef struct {
    bit          pend;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  req_t ip, dp;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: which source was served last, and the response due this cycle.
  bit          last_d;
  bit          exp_valid;
  bit          exp_d;
  bit          exp_err;
  logic [31:0] exp_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic cycle_start();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    i_req   = ip.pend;
    i_addr  = ip.addr;
    d_req   = dp.pend;
    d_we    = dp.we;
    d_addr  = dp.addr;
    d_wdata = dp.wdata;
    d_be    = dp.be;
  endtask

  task automatic new_i();
    ip.pend = 1'b1;
    ip.addr = $urandom;
  endtask

  task automatic new_d(input bit force_write);
    dp.pend  = 1'b1;
    dp.we    = force_write ? 1'b1 : 1'($urandom_range(0, 1));
    dp.addr  = $urandom;
    dp.wdata = $urandom;
    dp.be    = 4'($urandom_range(1, 15));
  endtask

  // Checks whatever response the model expects in the current cycle.
  task automatic check_resp();
    check("i_rvalid", i_rvalid, exp_valid && !exp_d);
    check("d_rvalid", d_rvalid, exp_valid && exp_d);
    if (exp_valid) begin
      if (exp_d) begin
        check("d_err", d_err, exp_err);
        check("d_rdata", d_rdata, exp_data);
      end else begin
        check("i_err", i_err, exp_err);
        check("i_rdata", i_rdata, exp_data);
      end
    end
    exp_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_fields"}, {mem_we, mem_addr, mem_wdata, mem_be}, 0);
    check({tag, "_i_out"}, {i_rvalid, i_err, i_rdata}, 0);
    check({tag, "_d_out"}, {d_rvalid, d_err, d_rdata}, 0);
  endtask

  // One transaction. Entered at the start of an idle cycle (c0), returns at the
  // start of the cycle the response is due (which is the next transaction's c0).
  // a: cycles of mem_ack delay; r: cycles between ack and mem_rvalid; resp_en=0: never.
  task automatic run_txn(input int a, input int r, input bit resp_en, input logic [31:0] rdata);
    bit          win_d, ok;
    logic        e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    int          ka, v, e, req_end;
    drive_reqs();
    #2;
    check_resp();
    check("idle_busy", busy, 0);
    if (ip.pend && dp.pend) win_d = !last_d;
    else                    win_d = dp.pend;
    check("i_gnt", i_gnt, !win_d);
    check("d_gnt", d_gnt, win_d);
    e_we    = win_d ? dp.we : 1'b0;
    e_addr  = win_d ? dp.addr : ip.addr;
    e_wdata = win_d ? dp.wdata : 32'h0;
    e_be    = win_d ? dp.be : 4'hF;
    last_d  = win_d;
    if (win_d) dp.pend = 1'b0;
    else       ip.pend = 1'b0;

    ka      = 1 + a;
    v       = ka + 1 + r;
    ok      = resp_en && (v <= TO);
    e       = ok ? v + 1 : TO + 1;
    req_end = (ka < TO) ? ka : TO;
    for (int k = 1; k < e; k++) begin
      cycle_start();
      drive_reqs();
      mem_ack    = (k == ka) || (k > ka && $urandom_range(0, 3) == 0);
      mem_rvalid = (resp_en && k == v) || (k < ka && $urandom_range(0, 3) == 0);
      mem_rdata  = (k == v) ? rdata : $urandom;
      #2;
      check("busy", busy, 1);
      check("gnt_while_busy", {i_gnt, d_gnt}, 0);
      check("rvalid_while_busy", {i_rvalid, d_rvalid}, 0);
      check("mem_req", mem_req, k <= req_end);
      if (k <= req_end)
        check("mem_fields", {mem_we, mem_addr, mem_wdata, mem_be}, {e_we, e_addr, e_wdata, e_be});
    end
    cycle_start();
    mem_ack    = 1'b0;
    mem_rvalid = !ok;  // a late response after a timeout must be ignored
    mem_rdata  = $urandom;
    exp_valid  = 1'b1;
    exp_d      = win_d;
    exp_err    = !ok;
    exp_data   = ok ? rdata : 32'h0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int a, r;
    bit en;
    ip = '{pend: 1'b0, we: 1'b0, addr: 32'h0, wdata: 32'h0, be: 4'h0};
    dp = '{pend: 1'b0, we: 1'b0, addr: 32'h0, wdata: 32'h0, be: 4'h0};
    last_d    = 1'b1;
    exp_valid = 1'b0;
    rst_n      = 1'b1;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    drive_reqs();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset_gnt", {i_gnt, d_gnt}, 0);
    rst_n = 1'b0;

    // Single fetch at 0x100, immediate ack, data next cycle.
    ip.pend = 1'b1;
    ip.addr = 32'h100;
    run_txn(0, 0, 1'b1, 32'hDEADBEEF);

    // Both ports requesting continuously: grants alternate.
    for (int n = 0; n < 4; n++) begin
      if (!ip.pend) new_i();
      if (!dp.pend) new_d(1'b1);
      run_txn(0, 0, 1'b1, $urandom);
    end

    // Pending D write with a 5-cycle ack delay.
    if (!dp.pend) new_d(1'b1);
    run_txn(5, 0, 1'b1, $urandom);

    // Ack then no response: timeout; next fetch served normally.
    new_i();
    run_txn(0, 0, 1'b0, 32'h0);
    new_i();
    run_txn(0, 1, 1'b1, $urandom);

    // Response arrives in the very cycle the timeout would fire.
    new_d(1'b0);
    run_txn(0, TO - 2, 1'b1, 32'hCAFEF00D);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      if (!ip.pend && $urandom_range(0, 1) == 1) new_i();
      if (!dp.pend && $urandom_range(0, 1) == 1) new_d(1'b0);
      if (!ip.pend && !dp.pend) new_i();
      a  = ($urandom_range(0, 9) == 0) ? TO + 1 : $urandom_range(0, 3);
      r  = $urandom_range(0, 4);
      en = ($urandom_range(0, 5) != 0);
      run_txn(a, r, en, $urandom);
    end
    while (ip.pend || dp.pend) run_txn(0, 0, 1'b1, $urandom);

    // Reset pulsed during WAIT.
    new_i();
    drive_reqs();
    #2;
    check_resp();
    check("rst_txn_gnt", i_gnt, 1);
    ip.pend = 1'b0;
    cycle_start();
    drive_reqs();
    mem_ack    = 1'b1;
    mem_rvalid = 1'b0;
    #2;
    check("rst_txn_mem_req", mem_req, 1);
    cycle_start();
    mem_ack = 1'b0;
    #2;
    check("rst_txn_busy", busy, 1);
    rst_n = 1'b1;
    #1;
    check_all_zero("mid_reset");
    rst_n = 1'b0;
    cycle_start();
    mem_rvalid = 1'b1;
    mem_rdata  = $urandom;
    #2;
    check("post_reset_busy", busy, 0);
    cycle_start();
    mem_rvalid = 1'b0;
    #2;
    check("post_reset_rvalid", {i_rvalid, d_rvalid}, 0);
    last_d = 1'b1;

    // After reset a tie goes to I, then D.
    cycle_start();
    new_i();
    new_d(1'b0);
    run_txn(0, 0, 1'b1, $urandom);
    run_txn(1, 2, 1'b1, $urandom);
    drive_reqs();
    #2;
    check_resp();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
